// File: rtl/GLOBAL_PARAM.sv
// GLOBAL_PARAM: accelerator-wide instruction width and bit-width helper.
package GLOBAL_PARAM;
    // 3-bit destination + 7-bit wait mask + 32-bit payload
    localparam int INST_W = 42;
    function automatic int bw(input int n);
        return $clog2(n + 1);
    endfunction
endpackage

// File: rtl/INS_CONST.sv
// INS_CONST: instruction field layout and dispatcher FSM states.
package INS_CONST;
    import GLOBAL_PARAM::*;
    localparam int DST_W = 3;
    localparam int WAIT_W = 7;
    localparam int INS_DST = INST_W - 1;
    localparam int INS_WAIT = INST_W - 4;
    localparam logic [DST_W-1:0] DST_CONF = 3'b111;
    typedef enum logic {S_FETCH, S_WAIT} state_t;
endpackage

// File: rtl/ins_dispatch_if.sv
// ins_dispatch_if: host instruction stream and per-engine instruction/done handshakes.
interface ins_dispatch_if #(parameter int ENG_NUM = 3);
    import GLOBAL_PARAM::*;
    logic                           ins_valid;
    logic                           ins_ready;
    logic [INST_W-1:0]              ins;
    logic [ENG_NUM-1:0]             eng_ins_valid;
    logic [ENG_NUM-1:0]             eng_ins_ready;
    logic [ENG_NUM-1:0][INST_W-1:0] eng_ins;
    logic [ENG_NUM-1:0]             eng_done;
    modport master(output ins_valid, ins, eng_ins_ready, eng_done, input ins_ready, eng_ins_valid, eng_ins);
    modport slave(input ins_valid, ins, eng_ins_ready, eng_done, output ins_ready, eng_ins_valid, eng_ins);
endinterface

// File: rtl/ins_fifo.sv
// ins_fifo: synchronous first-word-fall-through FIFO; a full FIFO may pop and push in one cycle.
module ins_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] dout
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0] wr_q, wr_d, rd_q, rd_d;
    always_comb begin
        wr_d = wr_q + PW'(push);
        rd_d = rd_q + PW'(pop);
        full = wr_q[AW] != rd_q[AW] && wr_q[AW-1:0] == rd_q[AW-1:0];
        empty = wr_q == rd_q;
        dout = mem_q[rd_q[AW-1:0]];
    end
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    always_ff @(posedge clk)
        if (push) mem_q[wr_q[AW-1:0]] <= din;
endmodule

// File: rtl/ins_dispatch.sv
// ins_dispatch: routes host instructions into per-engine FIFOs, holding each until its
// wait-mask engines are idle; configuration writes wait until every engine is idle.
module ins_dispatch
    import GLOBAL_PARAM::*;
    import INS_CONST::*;
#(
    parameter int ENG_NUM    = 3,
    parameter int FIFO_DEPTH = 4,
    parameter int CONF_W     = 32
) (
    input  logic              clk,
    input  logic              rst,
    ins_dispatch_if.slave     bus,
    output logic [CONF_W-1:0] conf,
    output logic              working,
    output logic              err
);
    localparam int OW = bw(FIFO_DEPTH + 1);
    state_t state_q, state_d;
    logic [INST_W-1:0] hold_q, hold_d;
    logic [CONF_W-1:0] conf_q, conf_d;
    logic [ENG_NUM-1:0][OW-1:0] outst_q, outst_d;
    logic err_q, err_d, working_q, working_d;
    logic [DST_W-1:0] dst, dst_in;
    logic [WAIT_W-1:0] busy;
    logic [ENG_NUM-1:0] sel, full, empty, push, pop;
    logic fetch, legal_in, all_idle, issue_eng, issue_conf;
    always_comb begin
        dst = hold_q[INS_DST -: DST_W];
        dst_in = bus.ins[INS_DST -: DST_W];
        legal_in = dst_in == DST_CONF || int'(dst_in) < ENG_NUM;
        fetch = state_q == S_FETCH && bus.ins_valid;
        busy = '0;
        sel = '0;
        for (int e = 0; e < ENG_NUM; e++) begin
            busy[e] = outst_q[e] != '0;
            sel[e] = dst == DST_W'(e);
        end
        all_idle = busy == '0;
        // a full FIFO still accepts when its head leaves this cycle
        issue_eng = state_q == S_WAIT && dst != DST_CONF
                    && (busy & hold_q[INS_WAIT -: WAIT_W]) == '0
                    && (sel & (~full | pop)) != '0;
        issue_conf = state_q == S_WAIT && dst == DST_CONF && all_idle;
        push = issue_eng ? sel : '0;
        state_d = fetch && legal_in ? S_WAIT : (issue_eng || issue_conf) ? S_FETCH : state_q;
        hold_d = fetch ? bus.ins : hold_q;
        conf_d = issue_conf ? hold_q[CONF_W-1:0] : conf_q;
        err_d = err_q || (fetch && !legal_in) || (bus.eng_done & ~busy[ENG_NUM-1:0]) != '0;
        working_d = state_q == S_WAIT || !all_idle;
        for (int e = 0; e < ENG_NUM; e++)
            outst_d[e] = push[e] && !bus.eng_done[e] ? outst_q[e] + OW'(1)
                       : bus.eng_done[e] && !push[e] && busy[e] ? outst_q[e] - OW'(1)
                       : outst_q[e];
    end
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            state_q <= S_FETCH;
            hold_q <= '0;
            conf_q <= '0;
            outst_q <= '0;
            err_q <= 1'b0;
            working_q <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q <= hold_d;
            conf_q <= conf_d;
            outst_q <= outst_d;
            err_q <= err_d;
            working_q <= working_d;
        end
    for (genvar i = 0; i < ENG_NUM; i++) begin : g_eng
        assign pop[i] = !empty[i] && bus.eng_ins_ready[i];
        ins_fifo #(.WIDTH(INST_W), .DEPTH(FIFO_DEPTH)) u_fifo (
            .clk(clk),
            .rst(rst),
            .push(push[i]),
            .din(hold_q),
            .pop(pop[i]),
            .full(full[i]),
            .empty(empty[i]),
            .dout(bus.eng_ins[i])
        );
    end
    assign bus.eng_ins_valid = ~empty;
    assign bus.ins_ready = state_q == S_FETCH;
    assign conf = conf_q;
    assign working = working_q;
    assign err = err_q;
endmodule

// File: tb/tb_ins_dispatch.sv
// tb_ins_dispatch: directed scenarios plus randomized traffic against a queue-based model.
module tb_ins_dispatch;
    import GLOBAL_PARAM::*;
    localparam int EN = 3;
    localparam int FD = 4;
    localparam int CW = 32;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    ins_dispatch_if #(.ENG_NUM(EN)) bus();
    logic [CW-1:0] conf;
    logic working, err;

    ins_dispatch #(.ENG_NUM(EN), .FIFO_DEPTH(FD), .CONF_W(CW)) dut (
        .clk(clk), .rst(rst), .bus(bus), .conf(conf), .working(working), .err(err)
    );

    logic [INST_W-1:0] mq[EN][$];
    int m_out[EN];
    int busy_t[EN];
    bit m_pend, m_err, m_work;
    logic [INST_W-1:0] m_hold;
    logic [CW-1:0] m_conf;
    bit rnd_rdy;
    logic [EN-1:0] hold_rdy, spur;
    int checks = 0;
    int fails = 0;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic timeout(string name);
        checks++;
        fails++;
        $display("FAIL %s: timed out", name);
    endtask

    function automatic logic [INST_W-1:0] mk(int dst, int wt, logic [31:0] pl);
        return {3'(dst), 7'(wt), pl};
    endfunction

    // every cycle out of reset: DUT outputs against the model
    always @(negedge clk) if (rst) begin
        check("ins_ready", 64'(bus.ins_ready), 64'(!m_pend));
        for (int e = 0; e < EN; e++) begin
            check($sformatf("eng_ins_valid[%0d]", e), 64'(bus.eng_ins_valid[e]), 64'(mq[e].size() > 0));
            if (mq[e].size() > 0)
                check($sformatf("eng_ins[%0d]", e), 64'(bus.eng_ins[e]), 64'(mq[e][0]));
        end
        check("conf", 64'(conf), 64'(m_conf));
        check("err", 64'(err), 64'(m_err));
        check("working", 64'(working), 64'(m_work));
    end

    task automatic model_step();
        bit was_pend = m_pend;
        bit any_out = 1'b0;
        bit blocked;
        bit pushed[EN];
        bit popped[EN];
        int d;
        for (int e = 0; e < EN; e++) begin
            any_out = any_out || m_out[e] != 0;
            pushed[e] = 1'b0;
            popped[e] = mq[e].size() > 0 && bus.eng_ins_ready[e] == 1'b1;
        end
        if (was_pend) begin
            d = int'(m_hold[INST_W-1 -: 3]);
            if (d == 7) begin
                if (!any_out) begin
                    m_conf = m_hold[CW-1:0];
                    m_pend = 1'b0;
                end
            end else begin
                blocked = 1'b0;
                for (int e = 0; e < EN; e++)
                    if (m_hold[INST_W-10+e] && m_out[e] != 0) blocked = 1'b1;
                if (!blocked && (mq[d].size() < FD || popped[d])) begin
                    pushed[d] = 1'b1;
                    m_pend = 1'b0;
                end
            end
        end
        for (int e = 0; e < EN; e++) begin
            if (popped[e]) void'(mq[e].pop_front());
            if (pushed[e]) mq[e].push_back(m_hold);
        end
        if (!was_pend && bus.ins_valid) begin
            d = int'(bus.ins[INST_W-1 -: 3]);
            if (d == 7 || d < EN) begin
                m_pend = 1'b1;
                m_hold = bus.ins;
            end else m_err = 1'b1;
        end
        for (int e = 0; e < EN; e++) begin
            if (bus.eng_done[e]) begin
                if (m_out[e] == 0) m_err = 1'b1;
                else if (!pushed[e]) m_out[e]--;
            end else if (pushed[e]) m_out[e]++;
        end
        m_work = was_pend || any_out;
    endtask

    // one clock: update model and engine timers at the edge, drive engines after the falling edge
    task automatic step();
        bit hs[EN];
        @(posedge clk);
        if (rst) begin
            for (int e = 0; e < EN; e++) hs[e] = mq[e].size() > 0 && bus.eng_ins_ready[e] == 1'b1;
            model_step();
            for (int e = 0; e < EN; e++) begin
                if (busy_t[e] > 0) busy_t[e]--;
                if (hs[e]) busy_t[e] = $urandom_range(1, 4);
            end
        end
        @(negedge clk);
        #1;
        for (int e = 0; e < EN; e++) begin
            bus.eng_ins_ready[e] = busy_t[e] == 0 && !hold_rdy[e] && (!rnd_rdy || $urandom_range(0, 3) != 0);
            bus.eng_done[e] = busy_t[e] == 1 || spur[e];
        end
        spur = '0;
    endtask

    task automatic send(logic [INST_W-1:0] x);
        bit acc;
        int n = 0;
        bus.ins_valid = 1'b1;
        bus.ins = x;
        do begin
            acc = !m_pend;
            step();
            n++;
        end while (!acc && n < 200);
        bus.ins_valid = 1'b0;
        if (!acc) timeout("send");
    endtask

    function automatic bit model_idle();
        bit r = !m_pend && !m_work;
        for (int e = 0; e < EN; e++) r = r && m_out[e] == 0 && mq[e].size() == 0;
        return r;
    endfunction

    task automatic wait_idle(int bound);
        int n = 0;
        while (!model_idle() && n < bound) begin
            step();
            n++;
        end
        if (!model_idle()) timeout("wait_idle");
    endtask

    task automatic do_reset();
        rst = 1'b0;
        bus.ins_valid = 1'b0;
        bus.ins = '0;
        bus.eng_ins_ready = '0;
        bus.eng_done = '0;
        hold_rdy = '0;
        spur = '0;
        for (int e = 0; e < EN; e++) begin
            mq[e].delete();
            m_out[e] = 0;
            busy_t[e] = 0;
        end
        m_pend = 1'b0;
        m_err = 1'b0;
        m_work = 1'b0;
        m_conf = '0;
        m_hold = '0;
        repeat (2) @(negedge clk);
        #1 rst = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [INST_W-1:0] a, c, first;
        int n, r;
        rnd_rdy = 1'b0;
        do_reset();
        check("rst_ins_ready", 64'(bus.ins_ready), 64'(1));
        check("rst_eng_valid", 64'(bus.eng_ins_valid), 64'(0));
        check("rst_conf", 64'(conf), 64'(0));
        check("rst_working", 64'(working), 64'(0));
        check("rst_err", 64'(err), 64'(0));

        // routing: each instruction is at its FIFO head two cycles after acceptance
        hold_rdy = '1;
        a = mk(0, 0, 32'h1111_0000);
        send(a);
        step();
        check("route0_valid", 64'(bus.eng_ins_valid[0]), 64'(1));
        check("route0_ins", 64'(bus.eng_ins[0]), 64'(a));
        send(mk(1, 0, 32'h2222_0000));
        c = mk(2, 0, 32'h3333_0000);
        send(c);
        step();
        check("route_valid", 64'(bus.eng_ins_valid), 64'(3'b111));
        check("route_working", 64'(working), 64'(1));

        // dependency on engine 0
        send(mk(2, 1, 32'h0000_000D));
        repeat (3) step();
        check("dep_stall", 64'(bus.ins_ready), 64'(0));
        hold_rdy[0] = 1'b0;
        n = 0;
        while (!bus.ins_ready && n < 50) begin
            step();
            n++;
        end
        if (!bus.ins_ready) timeout("dep_release");
        check("dep_head2", 64'(bus.eng_ins[2]), 64'(c));
        hold_rdy = '0;
        wait_idle(300);

        // back-pressure on engine 1
        hold_rdy[1] = 1'b1;
        first = mk(1, 0, 32'h0000_00B0);
        for (int k = 0; k <= FD; k++) send(mk(1, 0, 32'h0000_00B0 + k));
        repeat (2) step();
        check("bp_stall", 64'(bus.ins_ready), 64'(0));
        check("bp_head", 64'(bus.eng_ins[1]), 64'(first));
        hold_rdy = '0;
        wait_idle(300);

        // configuration barrier
        hold_rdy[1] = 1'b1;
        send(mk(1, 0, 32'h0000_00C1));
        send(mk(7, 0, 32'h0000_00A5));
        repeat (3) step();
        check("conf_blocked", 64'(conf), 64'(0));
        hold_rdy = '0;
        wait_idle(300);
        check("conf_written", 64'(conf), 64'(32'h0000_00A5));

        // randomized traffic
        rnd_rdy = 1'b1;
        repeat (3000) begin
            r = $urandom_range(0, 7);
            bus.ins_valid = $urandom_range(0, 1) == 1;
            bus.ins = mk(r == 7 ? 7 : r % EN, $urandom_range(0, 127), $urandom());
            step();
        end
        rnd_rdy = 1'b0;
        bus.ins_valid = 1'b0;
        wait_idle(500);
        check("rand_no_err", 64'(err), 64'(0));

        // reset mid-run with FIFOs partly full
        hold_rdy = '1;
        send(mk(0, 0, 32'h0000_0F01));
        send(mk(1, 0, 32'h0000_0F02));
        send(mk(0, 0, 32'h0000_0F03));
        step();
        #2 rst = 1'b0;
        #1;
        check("mid_rst_ins_ready", 64'(bus.ins_ready), 64'(1));
        check("mid_rst_eng_valid", 64'(bus.eng_ins_valid), 64'(0));
        check("mid_rst_conf", 64'(conf), 64'(0));
        check("mid_rst_working", 64'(working), 64'(0));
        check("mid_rst_err", 64'(err), 64'(0));
        do_reset();

        // done on an idle engine
        spur[0] = 1'b1;
        step();
        step();
        check("err_done", 64'(err), 64'(1));
        check("err_done_eng_valid", 64'(bus.eng_ins_valid), 64'(0));
        step();
        check("err_sticky", 64'(err), 64'(1));

        // illegal destination
        do_reset();
        send(mk(5, 0, 32'h0000_0055));
        step();
        check("err_dst", 64'(err), 64'(1));
        check("err_dst_ins_ready", 64'(bus.ins_ready), 64'(1));
        check("err_dst_eng_valid", 64'(bus.eng_ins_valid), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/ins_dispatch.md
# ins_dispatch

Parametrised instruction dispatcher for the CNN training accelerator. It accepts the host instruction stream and holds a per-engine FIFO for each of `ENG_NUM` execution engines (ddr2pe, pe_array, pe2ddr, and any added later). It routes each instruction to its destination engine and enforces cross-engine dependencies through a wait mask. It also applies layer-configuration instructions only when all engines are idle. It replaces the fixed three-way control split with a generic N-engine scoreboard, and adds outstanding-work tracking and error reporting.

## Interface
- `ENG_NUM`, 3: number of engines, 1..7.
- `FIFO_DEPTH`, 4: per-engine instruction FIFO depth, a power of two and at least 2.
- `CONF_W`, 32: width of the configuration payload.
- `clk`  in  1  clock; the block uses one clock.
- `rst`  in  1  reset, asynchronous and active-low.
- `ins_valid`  in  1  host instruction valid.
- `ins_ready`  out  1  host instruction ready.
- `ins`  in  `INST_W`  host instruction.
- `eng_ins_valid`  out  `ENG_NUM`  per-engine instruction valid.
- `eng_ins_ready`  in  `ENG_NUM`  per-engine ready; the engine holds it low while busy.
- `eng_ins`  out  `ENG_NUM`×`INST_W`  per-engine instruction (FIFO head).
- `eng_done`  in  `ENG_NUM`  one-cycle pulse per completed instruction.
- `conf`  out  `CONF_W`  current layer configuration register.
- `working`  out  1  the block holds or tracks unfinished work.
- `err`  out  1  sticky flag; set by `eng_done` on an engine with zero outstanding work.

## Operation
- **Instruction fields (package constants):**
  - `INS_DST` = `ins[INST_W-1 -: 3]`: the destination engine, 0..`ENG_NUM`-1.
  - `INS_DST` = 3'b111: a configuration instruction.
  - `INS_WAIT` = `ins[INST_W-4 -: 7]`: the wait mask; only bit e < `ENG_NUM` is used.
  - The configuration payload is `ins[CONF_W-1:0]`.
  - A destination of `ENG_NUM`..6 is illegal. Such an instruction is dropped and sets `err`.
- **`outst[e]` counter:**
  - Width is `bw(FIFO_DEPTH+1)`.
  - It counts the FIFO entries plus the one in-flight instruction; it increments on push and decrements on `eng_done[e]`.
  - A push and a done in the same cycle leave it unchanged.
  - A done while it is 0 leaves it at 0 and sets `err`.
- Engine e is idle when `outst[e]`==0.
- **FSM, two states:**
  - **S_FETCH:** `ins_ready`=1. When `ins_valid` is high, latch `ins` into `hold`, then go to S_WAIT.
  - **S_WAIT:** `ins_ready`=0. The issue condition is evaluated every cycle on the registered `outst`.
    - An engine instruction issues when every engine in the masked set is idle and FIFO[dst] is not full. It then pushes into FIFO[dst] and returns to S_FETCH.
    - A configuration instruction issues when all engines are idle. It then writes `conf` and returns to S_FETCH.
    - The wait mask bit for dst itself is legal; it serialises that engine.
- **Engine side:**
  - `eng_ins_valid[e]` = FIFO[e] not empty, and `eng_ins[e]` = the FIFO head.
  - A pop occurs on valid&&ready, with a standard valid/ready handshake.
  - The head stays stable while valid is high and ready is low.
- `working` = (state==S_WAIT) || any `outst`≠0. It is registered.
- `err` clears only on reset.

## Timing
- Reset values: `ins_ready`=1 (state S_FETCH), `eng_ins_valid`=0, `conf`=0, `working`=0, `err`=0, all `outst`=0, all FIFOs empty.
- Reset asserted mid-operation flushes all FIFOs and counters immediately, with no drain.
- Host acceptance at cycle N gives an earliest push at N+1, so throughput is 1 instruction per 2 cycles.
- A push at cycle N gives `eng_ins_valid` at N+1.
- `eng_done` at N updates `outst` at N+1; a dependent instruction can push at N+1.
- The FIFO can pop and push in the same cycle when full (pop first), so the FIFO remains full and the push succeeds.
- `working` lags its condition by one cycle.
- A configuration write is visible on `conf` the cycle after issue.

## Structure
- **Package `INS_CONST`:** `DST_W`=3, `WAIT_W`=7, `INS_DST`/`INS_WAIT` bit positions, `DST_CONF`=3'b111.
- **Package `GLOBAL_PARAM`:** `INST_W`, `bw()`.
- **Sub-module `ins_fifo`** (`WIDTH`, `DEPTH`): a synchronous first-word-fall-through FIFO with full/empty outputs, instantiated `ENG_NUM` times with generate.
- The FSM, the `outst` counters and the error logic live in `ins_dispatch`.

## Test plan
- **Basic routing:** send three instructions to dst 0, 1, 2 with wait=0 and all engines ready. Each appears on `eng_ins[e]` 2 cycles after acceptance, and `outst`=1 for each until its done.
- **Dependency:** send an instruction to dst 2 with wait=3'b001 while engine 0 has `outst`=1 and is held. `ins_ready` stays 0 until a cycle after `eng_done[0]`; the push to engine 2 then occurs in that cycle.
- **Back-pressure:** hold `eng_ins_ready[1]`=0 and send `FIFO_DEPTH`+1 instructions to dst 1. The FIFO fills, the last instruction stalls in S_WAIT, and `ins_ready`=0. Releasing ready drains the instructions in order.
- **Configuration barrier:** send configuration 0x0000_00A5 while engine 1 is busy. `conf` stays 0 until all `outst`=0, then reads 0xA5 a cycle later.
- **Errors:** pulse `eng_done[0]` with `outst[0]`=0, and separately send dst=5 with `ENG_NUM`=3. `err`=1 and stays high, `outst[0]` stays 0, and nothing is pushed.
- **Reset mid-run:** assert `rst` low with FIFOs partly full. All outputs return to their reset values the same cycle, and `working` is 0.
